// File: rtl/hv_bundler.sv
// hv_bundler: majority-vote bundling of NUM_HVS encoded hypervectors into one
// query hypervector. Each dimension keeps a running count of ones over the
// current window. The final accept of a window produces a strict-majority
// result, which is held until downstream takes it.
module hv_bundler #(
    parameter int DIMENSIONS = 10,
    parameter int NUM_HVS    = 5
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [DIMENSIONS-1:0]            hv_in,
    input  logic                             hv_in_valid,
    output logic                             hv_in_ready,
    output logic [DIMENSIONS-1:0]            hv_out,
    output logic                             hv_out_valid,
    input  logic                             hv_out_ready,
    output logic [$clog2(NUM_HVS+1)-1:0]     in_count
);

    // Counter width: large enough to hold NUM_HVS, so a counter never wraps.
    localparam int CW = $clog2(NUM_HVS + 1);

    // The sum width is one bit wider than a counter, so the final
    // counter+bit sum can never overflow, even at the top of the range.
    localparam int SW = CW + 1;

    // in_count value at which the next accept closes the window.
    localparam logic [CW-1:0] LAST_IDX = CW'(NUM_HVS - 1);

    // Strict majority: a bit wins only with more than floor(NUM_HVS/2) ones.
    // For even windows an exact tie resolves to 0.
    localparam logic [SW-1:0] THRESH = SW'(NUM_HVS / 2);

    localparam logic [0:0] ST_ACCUM = 1'b0;
    localparam logic [0:0] ST_HOLD  = 1'b1;

    logic [0:0]            r_state;
    logic [CW-1:0]         r_in_count;
    logic [DIMENSIONS-1:0] r_hv_out;

    logic                  w_accept;
    logic                  w_last;
    logic [DIMENSIONS-1:0] w_majority;

    // Handshake outputs are pure functions of the state. During reset,
    // hv_in_ready may still read 1, but w_accept masks the input.
    assign hv_in_ready  = (r_state == ST_ACCUM);
    assign hv_out_valid = (r_state == ST_HOLD);
    assign hv_out       = r_hv_out;
    assign in_count     = r_in_count;

    // A transfer happens only when both sides agree and the block is not in reset.
    assign w_accept = hv_in_valid & hv_in_ready & ~rst;

    // This accept completes the window.
    assign w_last   = w_accept & (r_in_count == LAST_IDX);

    // Per-dimension ones counter and majority decision.
    generate
        for (genvar gi = 0; gi < DIMENSIONS; gi++) begin : g_dim
            logic [CW-1:0] r_cnt;
            logic [SW-1:0] w_sum;

            // Include the current bit, so the last vector of the window
            // votes without an extra cycle.
            assign w_sum          = SW'(r_cnt) + SW'(hv_in[gi]);
            assign w_majority[gi] = (w_sum > THRESH);

            // Count ones on each accept. Clear on the closing accept or on reset.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cnt <= '0;
                end else if (w_last) begin
                    r_cnt <= '0;
                end else if (w_accept) begin
                    r_cnt <= r_cnt + CW'(hv_in[gi]);
                end
            end
        end
    endgenerate

    // Window fill level. It returns to zero on the closing accept,
    // so the next window counts from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_count <= '0;
        end else if (w_last) begin
            r_in_count <= '0;
        end else if (w_accept) begin
            r_in_count <= r_in_count + 1'b1;
        end
    end

    // Result register. It loads only on the closing accept. Because it is
    // not cleared on release, the value stays visible after HOLD.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hv_out <= '0;
        end else if (w_last) begin
            r_hv_out <= w_majority;
        end
    end

    // ACCUM collects inputs. HOLD presents the bundle until downstream takes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_ACCUM;
        end else begin
            case (r_state)
                ST_ACCUM: if (w_last)       r_state <= ST_HOLD;
                ST_HOLD:  if (hv_out_ready) r_state <= ST_ACCUM;
                default:                    r_state <= ST_ACCUM;
            endcase
        end
    end

endmodule

// File: doc/hv_bundler.md
HV_BUNDLER -- requirements
Module: hv_bundler

Interface
REQ-001 The block SHALL have parameter DIMENSIONS, default 10, giving the hypervector width in bits.
REQ-002 The block SHALL have parameter NUM_HVS, default 5, giving the number of input hypervectors bundled per window (legal range 1..255).
REQ-003 The block SHALL have port clk, input, 1 bit, as its single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, as a synchronous, active-high reset.
REQ-005 The block SHALL have port hv_in, input, DIMENSIONS bits, carrying the per-window encoded hypervector.
REQ-006 The block SHALL have port hv_in_valid, input, 1 bit, which is high when hv_in is valid.
REQ-007 The block SHALL have port hv_in_ready, output, 1 bit, which is high when the block can accept hv_in.
REQ-008 The block SHALL have port hv_out, output, DIMENSIONS bits, carrying the bundled query hypervector fed to the similarity stage.
REQ-009 The block SHALL have port hv_out_valid, output, 1 bit, which is high when hv_out holds a completed bundle.
REQ-010 The block SHALL have port hv_out_ready, input, 1 bit, which is high when downstream consumes hv_out.
REQ-011 The block SHALL have port in_count, output, clog2(NUM_HVS+1) bits, giving the number of inputs accepted in the current window.

Function
REQ-012 The block SHALL implement two states: ACCUM and HOLD.
REQ-013 In ACCUM, hv_in_ready SHALL be 1 and hv_out_valid SHALL be 0; in HOLD, hv_in_ready SHALL be 0 and hv_out_valid SHALL be 1.
REQ-014 An input is accepted only on a cycle with hv_in_valid=1, hv_in_ready=1 and rst=0; no other cycle SHALL change any counter.
REQ-015 On each accept, every per-dimension counter i (width clog2(NUM_HVS+1)) SHALL increment by hv_in[i], and in_count SHALL increment by 1.
REQ-016 On the accept that brings in_count to NUM_HVS, the block SHALL register hv_out[i] = 1 iff (counter[i] + hv_in[i]) > floor(NUM_HVS/2), clear all counters and in_count to 0, and enter HOLD.
REQ-017 The strict-majority rule SHALL be used, so for even NUM_HVS an exact tie yields 0.
REQ-018 Latency SHALL be one cycle: hv_out_valid rises on the cycle after the final accept.
REQ-019 In HOLD, hv_out SHALL remain stable and hv_in SHALL be ignored, however long hv_out_ready stays low.
REQ-020 In HOLD with hv_out_ready=1, the block SHALL return to ACCUM on the next edge; hv_out SHALL retain its value, and hv_in_ready SHALL be 1 the following cycle.
REQ-021 No counter SHALL wrap: by construction a counter never exceeds NUM_HVS.
REQ-022 With NUM_HVS=1, every accepted hv_in SHALL pass to hv_out unchanged after one cycle.
REQ-023 Idle cycles (hv_in_valid=0) in ACCUM SHALL hold all state.

Reset
REQ-024 When rst=1 at a clock edge, the next state SHALL be ACCUM, all counters and in_count SHALL be 0, hv_out SHALL be 0, and hv_out_valid SHALL be 0, regardless of the current state.
REQ-025 While rst=1, no input SHALL be accepted, even though hv_in_ready reads 1.
REQ-026 A reset mid-window or in HOLD SHALL discard the partial or pending bundle without emitting it.

Verification (DIMENSIONS=10, NUM_HVS=5)
REQ-027 Reset: rst high for 2 cycles -> hv_out=0000000000, hv_out_valid=0, in_count=0, hv_in_ready=1.
REQ-028 Majority: accept 0110000100 x3, then 0000000000 x2, with hv_out_ready=1 -> hv_out=0110000100 and hv_out_valid=1 exactly one cycle after the 5th accept, for one cycle.
REQ-029 Threshold edge: accept 1111111111 x2, then 0000000000 x3 -> hv_out=0000000000; accept 1111111111 x3, then 0000000000 x2 -> hv_out=1111111111.
REQ-030 Backpressure: hold hv_out_ready=0 for 10 cycles after a bundle while driving hv_in_valid=1 -> hv_out stable, hv_in_ready=0, in_count=0; then release -> the next window counts from 0.
REQ-031 Gaps: interleave accepts with 3 idle cycles each -> in_count steps 1..4 and the result matches the back-to-back case.
REQ-032 Mid-window reset: accept 1110011111 x3, pulse rst, then accept 0000000000 x5 -> hv_out=0000000000.
